// File: rtl/wave_capture_ctrl.sv
// Oscilloscope capture: edge or forced trigger fills a 512-sample back buffer, which is swapped to the display at vblank.
// vga_wave lags cnt_h/cnt_v by 2 clk; there is no sample backpressure, and samples arriving outside WAIT_TRIG/CAPTURE are dropped.
module wave_capture_ctrl #(
  parameter int          SAMPLE_W     = 8,
  parameter logic [15:0] AUTO_TIMEOUT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [3:0]          decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic                arm,
  input  logic                continuous,
  input  logic                abort,
  input  logic [9:0]          cnt_h,
  input  logic [9:0]          cnt_v,
  output logic                vga_wave,
  output logic                busy,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              st;
  logic [3:0]          dec_cnt;
  logic [15:0]         wait_cnt;
  logic [SAMPLE_W-1:0] prev;
  logic                prev_vld;
  logic [8:0]          addr;
  logic                sel;
  logic                disp_valid;

  // sel=0: mem0 is on display and mem1 is being written; sel=1 swaps the roles.
  logic [SAMPLE_W-1:0] mem0 [512];
  logic [SAMPLE_W-1:0] mem1 [512];
  logic [SAMPLE_W-1:0] rd0, rd1;

  logic       accept, trig_hit, forced, fire, wr_en, swap_pt, in_plot;
  logic [8:0] wr_addr, rd_addr;
  logic [7:0] row_y;

  assign accept   = sample_valid && (dec_cnt == decim);
  assign trig_hit = prev_vld && (trig_falling ? (prev >= trig_level && sample_data < trig_level)
                                              : (prev < trig_level && sample_data >= trig_level));
  assign forced   = continuous && (wait_cnt == AUTO_TIMEOUT);
  assign fire     = (st == WAIT_TRIG) && accept && (trig_hit || forced);
  assign wr_en    = !abort && (fire || (st == CAPTURE && accept));
  assign wr_addr  = (st == CAPTURE) ? addr : 9'd0;
  assign swap_pt  = (cnt_h == 10'd0) && (cnt_v == 10'd480);

  assign state = st;
  assign busy  = (st != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      dec_cnt    <= '0;
      wait_cnt   <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      addr       <= '0;
      sel        <= 1'b0;
      disp_valid <= 1'b0;
    end else if (abort) begin
      st       <= IDLE;
      dec_cnt  <= '0;
      wait_cnt <= '0;
      prev_vld <= 1'b0;
      addr     <= '0;
    end else begin
      if ((st == WAIT_TRIG || st == CAPTURE) && sample_valid)
        dec_cnt <= accept ? 4'd0 : dec_cnt + 4'd1;
      case (st)
        IDLE: begin
          if (arm || continuous) begin
            st       <= WAIT_TRIG;
            dec_cnt  <= '0;
            wait_cnt <= '0;
            prev_vld <= 1'b0;
            addr     <= '0;
          end
        end
        WAIT_TRIG: begin
          if (wait_cnt != AUTO_TIMEOUT)
            wait_cnt <= wait_cnt + 16'd1;
          if (accept) begin
            prev     <= sample_data;
            prev_vld <= 1'b1;
          end
          if (fire) begin
            st   <= CAPTURE;
            addr <= 9'd1;
          end
        end
        CAPTURE: begin
          if (accept) begin
            addr <= addr + 9'd1;
            if (addr == 9'd511)
              st <= DONE;
          end
        end
        DONE: begin
          if (swap_pt) begin
            sel        <= ~sel;
            disp_valid <= 1'b1;
            if (continuous) begin
              st       <= WAIT_TRIG;
              dec_cnt  <= '0;
              wait_cnt <= '0;
              prev_vld <= 1'b0;
              addr     <= '0;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && sel)
      mem0[wr_addr] <= sample_data;
    if (wr_en && !sel)
      mem1[wr_addr] <= sample_data;
    rd0 <= mem0[rd_addr];
    rd1 <= mem1[rd_addr];
  end

  // Row arithmetic is 8-bit: 367 mod 256 = 111, so 111 - cnt_v[7:0] gives 367 - cnt_v over the plot rows.
  assign in_plot = (cnt_h >= 10'd64) && (cnt_h < 10'd576) && (cnt_v >= 10'd112) && (cnt_v < 10'd368);
  assign rd_addr = cnt_h[8:0] - 9'd64;
  assign row_y   = 8'd111 - cnt_v[7:0];

  logic       in_plot_q, rd_sel_q;
  logic [7:0] row_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_plot_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      row_y_q   <= '0;
      vga_wave  <= 1'b0;
    end else begin
      in_plot_q <= in_plot;
      rd_sel_q  <= sel;
      row_y_q   <= row_y;
      vga_wave  <= in_plot_q && disp_valid && ((rd_sel_q ? rd1 : rd0) == row_y_q);
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Randomized bench for wave_capture_ctrl against a sample-list reference model of trigger, capture and display.
module tb_wave_capture_ctrl;
  localparam int AT = 40;

  logic       clk = 1'b0;
  logic       rst, sample_valid, trig_falling, arm, continuous, abort;
  logic [7:0] sample_data, trig_level;
  logic [3:0] decim;
  logic [9:0] cnt_h, cnt_v;
  logic       vga_wave, busy;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state, sample counts since arming, captured and displayed traces.
  int         m_state, m_vcnt, m_c, m_n;
  logic [7:0] m_prev;
  bit         m_pv, m_dv;
  logic [7:0] m_buf [512];
  logic [7:0] m_disp [512];

  wave_capture_ctrl #(.SAMPLE_W(8), .AUTO_TIMEOUT(16'(AT))) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .decim(decim), .trig_level(trig_level), .trig_falling(trig_falling), .arm(arm),
    .continuous(continuous), .abort(abort), .cnt_h(cnt_h), .cnt_v(cnt_v),
    .vga_wave(vga_wave), .busy(busy), .state(state)
  );

  always #10 clk = ~clk;

  task automatic m_enter_wait();
    m_state = 1; m_vcnt = 0; m_c = 0; m_pv = 0; m_n = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    bit acc, hit;
    acc = 0;
    if (abort) begin
      m_state = 0;
      return;
    end
    case (m_state)
      0: if (arm || continuous) m_enter_wait();
      1: begin
        if (sample_valid) begin
          m_vcnt++;
          acc = (m_vcnt % (int'(decim) + 1)) == 0;
        end
        if (acc) begin
          hit = m_pv && (trig_falling ? (m_prev >= trig_level && sample_data < trig_level)
                                      : (m_prev < trig_level && sample_data >= trig_level));
          if (hit || (continuous && m_c >= AT)) begin
            m_buf[0] = sample_data; m_n = 1; m_state = 2;
          end
          m_prev = sample_data; m_pv = 1;
        end
        m_c++;
      end
      2: if (sample_valid) begin
        m_vcnt++;
        if ((m_vcnt % (int'(decim) + 1)) == 0) begin
          m_buf[m_n] = sample_data; m_n++;
          if (m_n == 512) m_state = 3;
        end
      end
      default: if (cnt_h == 10'd0 && cnt_v == 10'd480) begin
        m_disp = m_buf; m_dv = 1;
        if (continuous) m_enter_wait(); else m_state = 0;
      end
    endcase
  endtask

  function automatic bit m_vga(input int h, input int v);
    if (!m_dv || h < 64 || h >= 576 || v < 112 || v >= 368) return 1'b0;
    return int'(m_disp[h-64]) == 367 - v;
  endfunction

  task automatic tick(output logic [1:0] st, output logic bz);
    m_step();
    @(negedge clk);
    st = state; bz = busy;
  endtask

  task automatic pix(input int h, input int v, output logic w);
    logic [1:0] s; logic b;
    cnt_h = 10'(h); cnt_v = 10'(v);
    sample_valid = 0; arm = 0; abort = 0;
    tick(s, b);
    tick(s, b);
    w = vga_wave;
  endtask

  task automatic start_arm(input string tag);
    logic [1:0] s; logic b;
    sample_valid = 0; arm = 1;
    tick(s, b);
    arm = 0;
    vectors++;
    if (s !== 2'd1 || b !== 1'b1) begin
      miscompares++;
      $display("FAIL %s arm: state %0d busy %0b, want 1/1", tag, s, b);
    end
  endtask

  // Kinds: 0 rising ramp, 1 falling ramp, 2 constant 50, 3 random. Spurious arm pulses while busy.
  task automatic run_capture(input int kind, input int vpct, input int stop_n, input string tag);
    logic [1:0] s; logic b;
    int idx = 0;
    int ncyc = 0;
    cnt_h = 10'd700; cnt_v = 10'd500;
    while (ncyc < 20000 && (m_state == 1 || (m_state == 2 && m_n < stop_n))) begin
      sample_valid = ($urandom_range(1, 100) <= vpct);
      case (kind)
        0: sample_data = 8'(idx);
        1: sample_data = 8'(255 - idx);
        2: sample_data = 8'd50;
        default: sample_data = 8'($urandom);
      endcase
      if (sample_valid) idx++;
      arm = ($urandom_range(0, 15) == 0);
      tick(s, b);
      ncyc++;
      vectors++;
      if (s !== 2'(m_state) || b !== (m_state != 0)) begin
        miscompares++;
        $display("FAIL %s cycle %0d: state %0d busy %0b, want %0d", tag, ncyc, s, b, m_state);
      end
    end
    arm = 0; sample_valid = 0;
    if (ncyc >= 20000) begin
      vectors++; miscompares++;
      $display("FAIL %s budget: model state %0d after %0d cycles", tag, m_state, ncyc);
    end
  endtask

  task automatic test_swap(input string tag);
    logic [1:0] s; logic b;
    sample_valid = 0; arm = 0; abort = 0;
    cnt_h = 10'd0; cnt_v = 10'd480;
    for (int k = 0; k < 2; k++) begin
      tick(s, b);
      vectors++;
      if (s !== 2'(m_state) || b !== (m_state != 0)) begin
        miscompares++;
        $display("FAIL %s swap cycle %0d: state %0d, want %0d", tag, k, s, m_state);
      end
    end
    cnt_h = 10'd700; cnt_v = 10'd500;
  endtask

  task automatic test_trace(input string tag);
    logic w; int r;
    for (int x = 0; x < 512; x++) begin
      pix(64 + x, 367 - int'(m_disp[x]), w);
      vectors++;
      if (w !== m_vga(64 + x, 367 - int'(m_disp[x]))) begin
        miscompares++;
        $display("FAIL %s hit x=%0d: vga %0b, want %0b", tag, x, w, m_vga(64 + x, 367 - int'(m_disp[x])));
      end
      r = (int'(m_disp[x]) + int'($urandom_range(1, 255))) % 256;
      pix(64 + x, 367 - r, w);
      vectors++;
      if (w !== m_vga(64 + x, 367 - r)) begin
        miscompares++;
        $display("FAIL %s miss x=%0d y=%0d: vga %0b, want %0b", tag, x, r, w, m_vga(64 + x, 367 - r));
      end
    end
  endtask

  task automatic test_reset();
    logic w;
    vectors++;
    if (state !== 2'd0 || busy !== 1'b0 || vga_wave !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: state %0d busy %0b vga %0b, want 0/0/0", state, busy, vga_wave);
    end
    rst = 0;
    pix(200, 200, w);
    vectors++;
    if (w !== 1'b0 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_release: vga %0b state %0d, want 0/0", w, state);
    end
  endtask

  task automatic test_rising_ramp();
    logic w;
    decim = 0; trig_falling = 0; trig_level = 8'd128;
    start_arm("rise");
    run_capture(0, 100, 512, "rise");
    vectors++;
    if (state !== 2'd3) begin
      miscompares++;
      $display("FAIL rise_done: state %0d, want 3", state);
    end
    test_swap("rise");
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL rise_idle_after_swap: state %0d, want 0", state);
    end
    pix(64, 367 - 128, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL rise_buf0: vga %0b, want 1", w); end
    pix(64 + 511, 367 - 127, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL rise_buf511: vga %0b, want 1", w); end
    test_trace("rise");
  endtask

  task automatic test_boundaries();
    logic w;
    int x0 = -1;
    int x255 = -1;
    int hv [8][2];
    for (int x = 0; x < 512; x++) begin
      if (m_disp[x] == 8'd0 && x0 < 0) x0 = x;
      if (m_disp[x] == 8'd255 && x255 < 0) x255 = x;
    end
    hv[0] = '{63, 367 - int'(m_disp[511])};
    hv[1] = '{576, 367 - int'(m_disp[0])};
    hv[2] = '{64, 367 - int'(m_disp[0])};
    hv[3] = '{575, 367 - int'(m_disp[511])};
    hv[4] = '{64 + x0, 111};
    hv[5] = '{64 + x0, 367};
    hv[6] = '{64 + x255, 368};
    hv[7] = '{64 + x255, 112};
    if (x0 >= 0 && x255 >= 0) begin
      for (int i = 0; i < 8; i++) begin
        pix(hv[i][0], hv[i][1], w);
        vectors++;
        if (w !== m_vga(hv[i][0], hv[i][1])) begin
          miscompares++;
          $display("FAIL boundary h=%0d v=%0d: vga %0b, want %0b", hv[i][0], hv[i][1], w, m_vga(hv[i][0], hv[i][1]));
        end
      end
    end
  endtask

  task automatic test_decim_falling();
    logic w;
    decim = 4'd3; trig_falling = 1; trig_level = 8'd100;
    start_arm("decim");
    run_capture(1, 60, 512, "decim");
    test_swap("decim");
    pix(64, 367 - 96, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL decim_first_sample: vga %0b, want 1", w); end
    pix(65, 367 - 92, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL decim_second_sample: vga %0b, want 1", w); end
    test_trace("decim");
  endtask

  task automatic test_random(input string tag);
    decim = 4'($urandom_range(0, 3));
    trig_falling = 1'($urandom_range(0, 1));
    trig_level = 8'($urandom_range(1, 254));
    start_arm(tag);
    run_capture(3, 70, 512, tag);
    test_swap(tag);
    test_trace(tag);
  endtask

  task automatic test_abort();
    logic [1:0] s; logic b; logic w; int x;
    decim = 0; trig_falling = 0; trig_level = 8'd128;
    start_arm("abort");
    run_capture(3, 100, 300, "abort");
    abort = 1;
    tick(s, b);
    abort = 0;
    vectors++;
    if (s !== 2'd0 || b !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_capture: state %0d busy %0b, want 0/0", s, b);
    end
    pix(0, 480, w);
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL abort_no_swap: state %0d, want 0", state); end
    for (int k = 0; k < 16; k++) begin
      x = $urandom_range(0, 511);
      pix(64 + x, 367 - int'(m_disp[x]), w);
      vectors++;
      if (w !== m_vga(64 + x, 367 - int'(m_disp[x]))) begin
        miscompares++;
        $display("FAIL abort_display x=%0d: vga %0b, want %0b", x, w, m_vga(64 + x, 367 - int'(m_disp[x])));
      end
    end
    arm = 1; abort = 1;
    tick(s, b);
    arm = 0; abort = 0;
    tick(s, b);
    vectors++;
    if (s !== 2'd0) begin miscompares++; $display("FAIL arm_abort_same_cycle: state %0d, want 0", s); end
  endtask

  task automatic test_reset_mid_capture();
    logic w;
    start_arm("rstmid");
    run_capture(3, 100, 100, "rstmid");
    pix(64, 367 - int'(m_disp[0]), w);
    vectors++;
    if (w !== m_vga(64, 367 - int'(m_disp[0]))) begin
      miscompares++;
      $display("FAIL rstmid_pre_hit: vga %0b, want %0b", w, m_vga(64, 367 - int'(m_disp[0])));
    end
    rst = 1;
    #1;
    vectors++;
    if (state !== 2'd0 || busy !== 1'b0 || vga_wave !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: state %0d busy %0b vga %0b, want 0/0/0", state, busy, vga_wave);
    end
    m_state = 0; m_dv = 0;
    @(negedge clk);
    rst = 0;
    pix(0, 480, w);
    pix(64, 367 - int'(m_disp[0]), w);
    vectors++;
    if (w !== 1'b0 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_after: vga %0b state %0d, want 0/0", w, state);
    end
  endtask

  task automatic test_continuous_timeout();
    logic [1:0] s; logic b; logic w;
    decim = 0; trig_falling = 0; trig_level = 8'd200;
    continuous = 1;
    tick(s, b);
    vectors++;
    if (s !== 2'd1) begin miscompares++; $display("FAIL cont_enter: state %0d, want 1", s); end
    run_capture(2, 100, 512, "cont1");
    test_swap("cont1");
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL cont_rearm: state %0d, want 1", state); end
    pix(64, 367 - 50, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL cont_flat_first: vga %0b, want 1", w); end
    pix(575, 367 - 50, w);
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL cont_flat_last: vga %0b, want 1", w); end
    test_trace("cont1");
    run_capture(2, 80, 512, "cont2");
    test_swap("cont2");
    pix(300, 367 - 50, w);
    vectors++;
    if (w !== 1'b1 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL cont_second: vga %0b state %0d, want 1/1", w, state);
    end
    continuous = 0; abort = 1;
    tick(s, b);
    abort = 0;
    vectors++;
    if (s !== 2'd0) begin miscompares++; $display("FAIL cont_abort: state %0d, want 0", s); end
  endtask

  initial begin
    rst = 1; sample_valid = 0; sample_data = 0; decim = 0; trig_level = 0;
    trig_falling = 0; arm = 0; continuous = 0; abort = 0;
    cnt_h = 10'd700; cnt_v = 10'd500;
    m_state = 0; m_dv = 0; m_n = 0; m_vcnt = 0; m_c = 0; m_pv = 0; m_prev = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_rising_ramp();
    test_boundaries();
    test_decim_falling();
    test_random("rand1");
    test_random("rand2");
    test_abort();
    test_reset_mid_capture();
    test_continuous_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_capture_ctrl.md
WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 Parameter: SAMPLE_W, default 8, sample width; the vertical plot span is 256 rows, so SAMPLE_W SHALL be 8.
REQ-002 Parameter: AUTO_TIMEOUT, default 16'hFFFF, clk cycles spent in WAIT_TRIG before a forced trigger in continuous mode.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock (50 MHz); all logic on posedge clk.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 sample_valid  in  1  sample strobe, one clk wide.
REQ-007 sample_data  in  8  unsigned ADC sample.
REQ-008 decim  in  4  keep every (decim+1)-th valid sample.
REQ-009 trig_level  in  8  trigger threshold.
REQ-010 trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-011 arm  in  1  single-shot arm pulse.
REQ-012 continuous  in  1  level; auto re-arm with forced trigger on timeout.
REQ-013 abort  in  1  pulse; cancel the capture in progress.
REQ-014 cnt_h, cnt_v  in  10 each  display scan counters; each value is held at least 2 clk cycles.
REQ-015 vga_wave  out  1  trace pixel flag for the display.
REQ-016 busy  out  1  high in WAIT_TRIG, CAPTURE and DONE.
REQ-017 state  out  2  encoding IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.

Function
REQ-018 Storage: two 512x8 buffers, a write buffer and a display buffer; a 1-bit select register swaps their roles.
REQ-019 Decimation: a 4-bit counter, cleared on entry to WAIT_TRIG, accepts a valid sample when it equals decim; it wraps to 0 on accept.
REQ-020 Edge detection uses prev, the last accepted sample; prev is invalid on entry to WAIT_TRIG.
  - Rising trigger: prev < trig_level and sample >= trig_level.
  - Falling trigger: prev >= trig_level and sample < trig_level.
REQ-021 IDLE -> WAIT_TRIG on an arm pulse or continuous=1.
REQ-022 WAIT_TRIG -> CAPTURE on the accepted sample that meets the trigger condition; that sample is written to address 0.
REQ-023 Forced trigger: in continuous mode, once the WAIT_TRIG cycle count reaches AUTO_TIMEOUT, the next accepted sample triggers unconditionally.
REQ-024 CAPTURE writes each accepted sample to the next sequential address; after address 511 is written -> DONE.
REQ-025 DONE waits for the swap point, cnt_h==0 and cnt_v==480 (first cycle it is seen).
  - At the swap point: toggle the select register and set disp_valid.
  - Then -> WAIT_TRIG if continuous=1, else -> IDLE.
REQ-026 abort returns to IDLE from any state within 1 cycle without a swap; abort wins over arm and continuous in the same cycle.
REQ-027 arm is ignored outside IDLE.
REQ-028 A sample arriving in the same cycle as the DONE transition is discarded.
REQ-029 Display lookup is active only inside the plot region: 64<=cnt_h<576 and 112<=cnt_v<368.
  - Read address x = cnt_h-64 (9 bits).
  - Target row y = 367-cnt_v (8 bits).
  - vga_wave=1 when disp_valid and disp_buf[x]==y.
REQ-030 vga_wave is registered with 2 clk latency from the cnt_h/cnt_v change; it is 0 outside the plot region.
REQ-031 The display buffer never changes except by the swap; a swap makes the complete new trace visible from the next frame.

Reset
REQ-032 On rst: state=IDLE, busy=0, vga_wave=0, select=0, disp_valid=0, address=0, counters=0, prev invalid.
REQ-033 Buffer contents are not reset; vga_wave is 0 until the first swap.
REQ-034 Reset asserted mid-CAPTURE discards the partial capture; no swap occurs.

Verification
REQ-035 Rising trigger: rst, trig_level=128, arm pulse, ramp 0..255 repeating with decim=0 -> CAPTURE starts at sample 128, buf[0]=128, buf[511]=127 (0..127 after wrap), DONE after 512 samples.
REQ-036 Swap and lookup: complete a capture, scan to cnt_v=480/cnt_h=0 -> swap; next frame vga_wave=1 at cnt_h=64+k only where cnt_v=367-buf[k], 2 clk after the counter change.
REQ-037 Decimation and falling edge: decim=3, trig_falling=1, trig_level=100, falling ramp -> only every 4th valid sample is stored, and the trigger fires on the first accepted sample <100.
REQ-038 Continuous and timeout: continuous=1 with a constant input of 50 and trig_level=200 -> forced trigger after AUTO_TIMEOUT cycles, trace is flat at y=50, capture re-arms after each swap.
REQ-039 Abort and reset: abort in CAPTURE at address 300 -> IDLE next cycle, display unchanged. arm and abort in the same cycle -> stays IDLE. rst mid-capture -> all outputs at reset values.
REQ-040 Boundaries: cnt_h=63/576 and cnt_v=111/368 -> vga_wave=0. arm pulse while busy -> ignored.
